// File: rtl/lighthouse_gen_pkg.sv
// Shared definitions for the synthetic lighthouse base-station emitter.
//   - gen_state_e : emitter FSM state encoding
//   - DEF_*       : default timing constants (50 MHz tick base)
//   - sync_len()  : sync pulse width for a given skip/data/axis code
package lighthouse_gen_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SYNC  = 2'd1,
    ST_SWEEP = 2'd2
  } gen_state_e;

  localparam int DEF_NUM_SENSORS       = 16;
  localparam int DEF_CYCLE_TICKS       = 416666;
  localparam int DEF_SYNC_BASE_TICKS   = 3125;
  localparam int DEF_SYNC_STEP_TICKS   = 521;
  localparam int DEF_SWEEP_WIDTH_TICKS = 100;
  localparam int DEF_SYNC_GUARD_TICKS  = 8000;
  localparam int DEF_CNT_W             = 19;

  // Sync width encodes code = skip*4 + data*2 + axis.
  function automatic int unsigned sync_len(
    input logic        skip,
    input logic        data,
    input logic        axis,
    input int unsigned base = DEF_SYNC_BASE_TICKS,
    input int unsigned step = DEF_SYNC_STEP_TICKS
  );
    logic [2:0] code;
    code = {skip, data, axis};
    return base + step * 32'(code);
  endfunction

endpackage

// File: rtl/lighthouse_sweep_cmp.sv
// Per-sensor sweep pulse generator.
//   clk, reset_n  : clock, asynchronous active-low reset
//   wr_en         : load wr_offset into the shadow offset
//   wr_offset     : new sweep offset (ticks from sync start)
//   cycle_start   : copy shadow -> active offset (cycle boundary)
//   sync_next     : next state is SYNC (output forced high)
//   sweep_next    : next state is SWEEP (window compare enabled)
//   tick_next     : tick counter value after the coming edge
//   sensor_signal : registered envelope output, high = light
module lighthouse_sweep_cmp #(
  parameter int CNT_W             = 19,
  parameter int SWEEP_WIDTH_TICKS = 100,
  parameter int SYNC_GUARD_TICKS  = 8000
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             wr_en,
  input  logic [CNT_W-1:0] wr_offset,
  input  logic             cycle_start,
  input  logic             sync_next,
  input  logic             sweep_next,
  input  logic [CNT_W-1:0] tick_next,
  output logic             sensor_signal
);

  localparam logic [CNT_W:0] GUARD_X = (CNT_W+1)'(SYNC_GUARD_TICKS);
  localparam logic [CNT_W:0] WIDTH_X = (CNT_W+1)'(SWEEP_WIDTH_TICKS);

  logic [CNT_W-1:0] shadow_q;
  logic [CNT_W-1:0] active_q;
  logic [CNT_W:0]   tick_x;
  logic [CNT_W:0]   off_x;
  logic [CNT_W:0]   end_x;
  logic             hit;

  // One extra bit so offset + width cannot wrap near the top of the range.
  always_comb begin
    tick_x = {1'b0, tick_next};
    off_x  = {1'b0, active_q};
    end_x  = off_x + WIDTH_X;
    hit    = sweep_next && (off_x >= GUARD_X) &&
             (tick_x >= off_x) && (tick_x < end_x);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shadow_q      <= '0;
      active_q      <= '0;
      sensor_signal <= 1'b0;
    end else begin
      if (wr_en) shadow_q <= wr_offset;
      // A write on the cycle-start edge lands in shadow only; active picks
      // up the previous shadow value and the new one waits a full cycle.
      if (cycle_start) active_q <= shadow_q;
      sensor_signal <= sync_next | hit;
    end
  end

endmodule

// File: rtl/lighthouse_sweep_gen.sv
// Synthetic lighthouse emitter: sync flash on all sensors (width encodes
// skip/data/axis) followed by a per-sensor sweep pulse at a programmed tick.
//   clk, reset_n     : clock, asynchronous active-low reset
//   enable_i         : run request, checked only at cycle boundaries
//   skip_i           : skip bit, sampled at cycle start
//   data_word_i      : OOTX word, latched at bit 0, sent LSB first
//   cfg_wr_i         : shadow offset write strobe
//   cfg_sensor_i     : sensor index for the write (out of range ignored)
//   cfg_offset_i     : sweep offset in ticks from sync start
//   sensor_signal_o  : registered envelope outputs
//   sync_active_o    : high during the sync pulse
//   axis_o           : axis of the current cycle
//   cycle_strobe_o   : one-clock pulse at tick 0 of each cycle
//   state_dbg_o      : current FSM state
// Handshake: none; cfg_wr_i is a single-cycle strobe, always accepted.
// All outputs are registered from the next-state/next-tick values, so each
// output matches the state and tick held after the same clock edge.
module lighthouse_sweep_gen
  import lighthouse_gen_pkg::*;
#(
  parameter int NUM_SENSORS       = DEF_NUM_SENSORS,
  parameter int CYCLE_TICKS       = DEF_CYCLE_TICKS,
  parameter int SYNC_BASE_TICKS   = DEF_SYNC_BASE_TICKS,
  parameter int SYNC_STEP_TICKS   = DEF_SYNC_STEP_TICKS,
  parameter int SWEEP_WIDTH_TICKS = DEF_SWEEP_WIDTH_TICKS,
  parameter int SYNC_GUARD_TICKS  = DEF_SYNC_GUARD_TICKS,
  parameter int CNT_W             = DEF_CNT_W
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   enable_i,
  input  logic                   skip_i,
  input  logic [31:0]            data_word_i,
  input  logic                   cfg_wr_i,
  input  logic [3:0]             cfg_sensor_i,
  input  logic [CNT_W-1:0]       cfg_offset_i,
  output logic [NUM_SENSORS-1:0] sensor_signal_o,
  output logic                   sync_active_o,
  output logic                   axis_o,
  output logic                   cycle_strobe_o,
  output logic [1:0]             state_dbg_o
);

  localparam logic [CNT_W-1:0] LAST_TICK = CNT_W'(CYCLE_TICKS - 1);

  gen_state_e       state_q, state_d;
  logic [CNT_W-1:0] tick_q, tick_d;
  logic             cycle_start;
  logic [4:0]       bit_idx_q;
  logic [31:0]      word_q;
  logic [31:0]      next_word;
  logic             data_bit;
  logic             axis_pend_q;
  logic [CNT_W-1:0] sync_len_q;
  logic [CNT_W-1:0] sync_len_d;

  assign state_dbg_o = state_q;

  always_comb begin
    state_d     = state_q;
    tick_d      = tick_q;
    cycle_start = 1'b0;
    case (state_q)
      ST_IDLE: begin
        tick_d = '0;
        if (enable_i) begin
          state_d     = ST_SYNC;
          cycle_start = 1'b1;
        end
      end
      ST_SYNC: begin
        tick_d = tick_q + CNT_W'(1);
        if (tick_q == sync_len_q - CNT_W'(1)) state_d = ST_SWEEP;
      end
      ST_SWEEP: begin
        if (tick_q == LAST_TICK) begin
          tick_d = '0;
          if (enable_i) begin
            state_d     = ST_SYNC;
            cycle_start = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          tick_d = tick_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        tick_d  = '0;
      end
    endcase
  end

  // The data word is captured only when a new 32-bit frame begins.
  always_comb begin
    next_word  = (bit_idx_q == 5'd0) ? data_word_i : word_q;
    data_bit   = next_word[bit_idx_q];
    sync_len_d = CNT_W'(sync_len(skip_i, data_bit, axis_pend_q,
                                 SYNC_BASE_TICKS, SYNC_STEP_TICKS));
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= ST_IDLE;
      tick_q         <= '0;
      bit_idx_q      <= '0;
      word_q         <= '0;
      axis_pend_q    <= 1'b0;
      sync_len_q     <= '0;
      sync_active_o  <= 1'b0;
      axis_o         <= 1'b0;
      cycle_strobe_o <= 1'b0;
    end else begin
      state_q        <= state_d;
      tick_q         <= tick_d;
      sync_active_o  <= (state_d == ST_SYNC);
      cycle_strobe_o <= cycle_start;
      if (cycle_start) begin
        word_q      <= next_word;
        bit_idx_q   <= bit_idx_q + 5'd1;
        sync_len_q  <= sync_len_d;
        axis_o      <= axis_pend_q;
        axis_pend_q <= ~axis_pend_q;
      end
    end
  end

  for (genvar g = 0; g < NUM_SENSORS; g++) begin : g_sensor
    lighthouse_sweep_cmp #(
      .CNT_W             (CNT_W),
      .SWEEP_WIDTH_TICKS (SWEEP_WIDTH_TICKS),
      .SYNC_GUARD_TICKS  (SYNC_GUARD_TICKS)
    ) u_cmp (
      .clk           (clk),
      .reset_n       (reset_n),
      .wr_en         (cfg_wr_i && (32'(cfg_sensor_i) == g)),
      .wr_offset     (cfg_offset_i),
      .cycle_start   (cycle_start),
      .sync_next     (state_d == ST_SYNC),
      .sweep_next    (state_d == ST_SWEEP),
      .tick_next     (tick_d),
      .sensor_signal (sensor_signal_o[g])
    );
  end

endmodule

// File: tb/tb_lighthouse_sweep_gen.sv
// Directed bench for lighthouse_sweep_gen with shortened timing constants:
// cycle 400 ticks, sync 30 + 5*code, sweep width 10, guard 100.
module tb_lighthouse_sweep_gen;

  localparam int NS    = 16;
  localparam int CYC   = 400;
  localparam int BASE  = 30;
  localparam int STEP  = 5;
  localparam int WIDTH = 10;
  localparam int GUARD = 100;
  localparam int CW    = 19;

  logic          clk;
  logic          reset_n;
  logic          enable_i;
  logic          skip_i;
  logic [31:0]   data_word_i;
  logic          cfg_wr_i;
  logic [3:0]    cfg_sensor_i;
  logic [CW-1:0] cfg_offset_i;
  logic [NS-1:0] sensor_signal_o;
  logic          sync_active_o;
  logic          axis_o;
  logic          cycle_strobe_o;
  logic [1:0]    state_dbg_o;

  lighthouse_sweep_gen #(
    .NUM_SENSORS       (NS),
    .CYCLE_TICKS       (CYC),
    .SYNC_BASE_TICKS   (BASE),
    .SYNC_STEP_TICKS   (STEP),
    .SWEEP_WIDTH_TICKS (WIDTH),
    .SYNC_GUARD_TICKS  (GUARD),
    .CNT_W             (CW)
  ) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .enable_i        (enable_i),
    .skip_i          (skip_i),
    .data_word_i     (data_word_i),
    .cfg_wr_i        (cfg_wr_i),
    .cfg_sensor_i    (cfg_sensor_i),
    .cfg_offset_i    (cfg_offset_i),
    .sensor_signal_o (sensor_signal_o),
    .sync_active_o   (sync_active_o),
    .axis_o          (axis_o),
    .cycle_strobe_o  (cycle_strobe_o),
    .state_dbg_o     (state_dbg_o)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  int checks   = 0;
  int failures = 0;

  task automatic check_val(input string tag, input logic [31:0] got,
                           input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // Per-cycle observations.
  int sync_cnt, bad_sync, strobe_cnt, axis_chg;
  logic axis_at0;
  int hi_cnt [NS];
  int first_hi [NS];

  // ---------------- driver tasks ----------------
  task automatic cfg_write(input int sensor, input int off);
    cfg_wr_i     = 1'b1;
    cfg_sensor_i = 4'(sensor);
    cfg_offset_i = CW'(off);
    @(negedge clk);
    cfg_wr_i = 1'b0;
  endtask

  task automatic wait_strobe(input string tag);
    int found;
    found = 0;
    for (int i = 0; i < 20; i++) begin
      if (cycle_strobe_o === 1'b1) begin
        found = 1;
        break;
      end
      @(negedge clk);
    end
    check_val(tag, found, 1);
  endtask

  // Called at the negedge where tick 0 is visible; samples every tick of
  // one cycle and returns positioned at the following tick-0 negedge.
  task automatic observe_cycle(input int wr_tick, input int wr_sensor,
                               input int wr_off, input int drop_tick);
    sync_cnt = 0; bad_sync = 0; strobe_cnt = 0; axis_chg = 0;
    axis_at0 = axis_o;
    for (int s = 0; s < NS; s++) begin
      hi_cnt[s]   = 0;
      first_hi[s] = -1;
    end
    for (int t = 0; t < CYC; t++) begin
      if (sync_active_o) begin
        sync_cnt++;
        if (sensor_signal_o !== '1) bad_sync++;
      end else begin
        for (int s = 0; s < NS; s++)
          if (sensor_signal_o[s]) begin
            if (first_hi[s] < 0) first_hi[s] = t;
            hi_cnt[s]++;
          end
      end
      if (cycle_strobe_o) strobe_cnt++;
      if (axis_o !== axis_at0) axis_chg++;
      cfg_wr_i = 1'b0;
      if (t == wr_tick) begin
        cfg_wr_i     = 1'b1;
        cfg_sensor_i = 4'(wr_sensor);
        cfg_offset_i = CW'(wr_off);
      end
      if (t == drop_tick) enable_i = 1'b0;
      @(negedge clk);
    end
    cfg_wr_i = 1'b0;
  endtask

  task automatic check_cycle(input string tag, input int exp_sync,
                             input logic exp_axis);
    check_val({tag, "_sync_len"}, sync_cnt, exp_sync);
    check_val({tag, "_axis"}, {31'd0, axis_at0}, {31'd0, exp_axis});
    check_val({tag, "_sync_all_high"}, bad_sync, 0);
    check_val({tag, "_strobe_once"}, strobe_cnt, 1);
    check_val({tag, "_axis_stable"}, axis_chg, 0);
  endtask

  function automatic int others_hi(input int a, input int b);
    int sum;
    sum = 0;
    for (int s = 0; s < NS; s++)
      if (s != a && s != b) sum += hi_cnt[s];
    return sum;
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    int idle_act;
    int exp_sync;
    logic exp_data;

    reset_n = 1'b0; enable_i = 1'b0; skip_i = 1'b0; data_word_i = '0;
    cfg_wr_i = 1'b0; cfg_sensor_i = '0; cfg_offset_i = '0;
    repeat (3) @(negedge clk);
    check_val("rst_sensors", sensor_signal_o, 0);
    check_val("rst_sync", sync_active_o, 0);
    check_val("rst_axis", axis_o, 0);
    check_val("rst_strobe", cycle_strobe_o, 0);
    check_val("rst_state", state_dbg_o, 0);
    reset_n = 1'b1;
    @(negedge clk);

    // Offsets written in IDLE: sensor 3 normal, sensor 4 below guard,
    // sensor 7 near cycle end (ticks 394..399 -> 6 clocks).
    cfg_write(3, 150);
    cfg_write(4, 50);
    cfg_write(7, 394);
    repeat (3) @(negedge clk);
    check_val("idle_sensors", sensor_signal_o, 0);

    enable_i = 1'b1;
    @(negedge clk);
    wait_strobe("start_c0");

    observe_cycle(-1, 0, 0, -1);
    check_cycle("c0", 30, 1'b0);
    check_val("c0_s3_first", first_hi[3], 150);
    check_val("c0_s3_len", hi_cnt[3], 10);
    check_val("c0_s4_guard", hi_cnt[4], 0);
    check_val("c0_s7_first", first_hi[7], 394);
    check_val("c0_s7_trunc_len", hi_cnt[7], 6);
    check_val("c0_others_low", others_hi(3, 7), 0);
    check_val("c0_period", cycle_strobe_o, 1);

    observe_cycle(-1, 0, 0, -1);
    check_cycle("c1", 35, 1'b1);
    check_val("c1_period", cycle_strobe_o, 1);

    // Mid-cycle offset change applies next cycle.
    observe_cycle(80, 3, 250, -1);
    check_cycle("c2", 30, 1'b0);
    check_val("c2_s3_first_old", first_hi[3], 150);

    // Write on the cycle-start edge: lands in shadow, applies a cycle later.
    observe_cycle(CYC - 1, 3, 300, -1);
    check_cycle("c3", 35, 1'b1);
    check_val("c3_s3_first_new", first_hi[3], 250);

    observe_cycle(-1, 0, 0, -1);
    check_cycle("c4", 30, 1'b0);
    check_val("c4_s3_first_still", first_hi[3], 250);

    observe_cycle(-1, 0, 0, -1);
    check_cycle("c5", 35, 1'b1);
    check_val("c5_s3_first_late", first_hi[3], 300);

    observe_cycle(-1, 0, 0, -1);
    check_cycle("c6", 30, 1'b0);

    // Reset during the sync of an axis-1 cycle.
    repeat (20) @(negedge clk);
    check_val("pre_rst_sync", sync_active_o, 1);
    check_val("pre_rst_axis", axis_o, 1);
    reset_n = 1'b0;
    #1;
    check_val("async_rst_sensors", sensor_signal_o, 0);
    check_val("async_rst_sync", sync_active_o, 0);
    check_val("async_rst_axis", axis_o, 0);
    check_val("async_rst_state", state_dbg_o, 0);
    enable_i = 1'b0;
    repeat (3) @(negedge clk);
    reset_n     = 1'b1;
    skip_i      = 1'b1;
    data_word_i = 32'h0000_0001;
    @(negedge clk);
    enable_i = 1'b1;
    @(negedge clk);
    wait_strobe("start_r0");

    // 33 cycles: word 1 latched at bit 0; the live input is changed to a
    // word with bits 1..30 set, then to 0 before the wrap re-latch.
    for (int k = 0; k <= 32; k++) begin
      if (k == 1)  data_word_i = 32'h7FFF_FFFE;
      if (k == 31) data_word_i = 32'h0000_0000;
      if (k == 31) observe_cycle(200, 7, 394, -1);
      else         observe_cycle(-1, 0, 0, -1);
      exp_data = (k == 0);
      exp_sync = BASE + STEP * (4 + 2 * int'(exp_data) + (k % 2));
      check_cycle($sformatf("r%0d", k), exp_sync, 1'((k % 2)));
      if (k == 0) check_val("r0_offsets_cleared", others_hi(-1, -1), 0);
    end
    check_val("r32_s7_first", first_hi[7], 394);
    check_val("r32_s7_len", hi_cnt[7], 6);

    // Drop enable mid-sweep: cycle runs to its last tick, then IDLE.
    observe_cycle(-1, 0, 0, 100);
    check_cycle("r33", 55, 1'b1);
    check_val("r33_s7_len_full_cycle", hi_cnt[7], 6);
    idle_act = 0;
    for (int i = 0; i < 20; i++) begin
      if (sensor_signal_o !== '0 || sync_active_o !== 1'b0 ||
          cycle_strobe_o !== 1'b0) idle_act++;
      @(negedge clk);
    end
    check_val("idle_outputs_low", idle_act, 0);
    check_val("idle_state", state_dbg_o, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global time limit so the run always ends.
  initial begin
    #2_000_000;
    $display("FAIL timeout got=%0d expected=%0d", 0, 1);
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
